// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: execute-stage request/response bundle between the pipeline and the multiply/divide unit
// Signals:
//   flushE, start, op[2:0], a[31:0], b[31:0]  pipeline -> unit (master drives)
//   stall_o, we_o[1:0], hi_o[31:0], lo_o[31:0] unit -> pipeline/HI-LO file (slave drives)
interface mul_div_unit_if;
   logic        flushE;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        stall_o;
   logic [1:0]  we_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   modport master (output flushE, start, op, a, b, input stall_o, we_o, hi_o, lo_o);
   modport slave (input flushE, start, op, a, b, output stall_o, we_o, hi_o, lo_o);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: MIPS execute-stage multiply/divide unit feeding the HI/LO register file
// Ports:
//   clk            core clock, rising edge
//   rst            synchronous active-high reset
//   bus (slave)    flushE/start/op/a/b in; stall_o, we_o ([1]=HI,[0]=LO), hi_o, lo_o out
// MULT/MULTU and MTHI/MTLO complete in the start cycle; DIV/DIVU use a 32-step
// restoring divider and stall the pipeline for 33 cycles.
// Optional: define MDU_MUL_2CYCLE_EN to register the product and deliver it one cycle later.
module mul_div_unit #(
   parameter int DIV_ITERS = 32
) (
   input logic           clk,
   input logic           rst,
   mul_div_unit_if.slave bus
);
   localparam logic [2:0] OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3, OP_DIVU = 3'd4,
                          OP_MTHI = 3'd5, OP_MTLO = 3'd6;
`ifdef MDU_MUL_2CYCLE_EN
   typedef enum logic [1:0] {IDLE, DIV_BUSY, DONE, MUL_WAIT} state_t;
`else
   typedef enum logic [1:0] {IDLE, DIV_BUSY, DONE} state_t;
`endif
   state_t      state;
   logic [4:0]  cnt;
   logic [31:0] rem, quo, dvs;
   logic        sa, sb, sgn;
   logic        is_mul, is_div, sop;
   logic [63:0] xa, xb, prod;
   logic [31:0] ua, ub, qn, rn;
   logic [32:0] r33, trial;
   assign is_mul = bus.op == OP_MULT || bus.op == OP_MULTU;
   assign is_div = bus.op == OP_DIV || bus.op == OP_DIVU;
   assign sop    = bus.op == OP_MULT || bus.op == OP_DIV;
   // Low 64 bits of the extended product equal the signed or unsigned 32x32 product
   assign xa   = sop ? {{32{bus.a[31]}}, bus.a} : {32'b0, bus.a};
   assign xb   = sop ? {{32{bus.b[31]}}, bus.b} : {32'b0, bus.b};
   assign prod = xa * xb;
   assign ua   = (sop && bus.a[31]) ? -bus.a : bus.a;
   assign ub   = (sop && bus.b[31]) ? -bus.b : bus.b;
   // quo starts as the dividend; its MSB shifts into rem while quotient bits enter at the LSB
   assign r33   = {rem, quo[31]};
   assign trial = r33 - {1'b0, dvs};
   // Divide by zero keeps the all-ones quotient; the remainder correction restores the raw dividend
   assign qn = (sgn && (sa ^ sb) && dvs != 32'd0) ? -quo : quo;
   assign rn = (sgn && sa) ? -rem : rem;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         rem   <= '0;
         quo   <= '0;
         dvs   <= '0;
         sa    <= 1'b0;
         sb    <= 1'b0;
         sgn   <= 1'b0;
      end else if (bus.flushE) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start && is_div) begin
                  rem   <= '0;
                  quo   <= ua;
                  dvs   <= ub;
                  sa    <= bus.a[31];
                  sb    <= bus.b[31];
                  sgn   <= sop;
                  cnt   <= '0;
                  state <= DIV_BUSY;
               end
`ifdef MDU_MUL_2CYCLE_EN
               else if (bus.start && is_mul) begin
                  {rem, quo} <= prod;
                  state      <= MUL_WAIT;
               end
`endif
            end
            DIV_BUSY: begin
               rem <= trial[32] ? r33[31:0] : trial[31:0];
               quo <= {quo[30:0], ~trial[32]};
               cnt <= cnt + 5'd1;
               if (cnt == 5'(DIV_ITERS - 1)) state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end
   always_comb begin
      bus.stall_o = 1'b0;
      bus.we_o    = 2'b00;
      bus.hi_o    = '0;
      bus.lo_o    = '0;
      if (!bus.flushE) begin
         case (state)
            IDLE: begin
               if (bus.start) begin
`ifdef MDU_MUL_2CYCLE_EN
                  bus.stall_o = is_div || is_mul;
`else
                  bus.stall_o = is_div;
                  if (is_mul) begin
                     bus.we_o = 2'b11;
                     {bus.hi_o, bus.lo_o} = prod;
                  end
`endif
                  if (bus.op == OP_MTHI) begin
                     bus.we_o = 2'b10;
                     bus.hi_o = bus.a;
                  end
                  if (bus.op == OP_MTLO) begin
                     bus.we_o = 2'b01;
                     bus.lo_o = bus.a;
                  end
               end
            end
            DIV_BUSY: bus.stall_o = 1'b1;
            DONE: begin
               bus.we_o = 2'b11;
               bus.hi_o = sgn ? rn : rem;
               bus.lo_o = sgn ? qn : quo;
            end
`ifdef MDU_MUL_2CYCLE_EN
            MUL_WAIT: begin
               bus.we_o = 2'b11;
               bus.hi_o = rem;
               bus.lo_o = quo;
            end
`endif
            default: bus.stall_o = 1'b0;
         endcase
      end
   end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for mul_div_unit against an arithmetic reference model
module tb_mul_div_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [65:0] sb[$];
   mul_div_unit_if bus();
   mul_div_unit dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   initial begin
      #500000;
      $display("FAIL global_timeout got running required finished");
      $fatal(1, "timeout");
   end
   // Returns {we, hi, lo} for a completed operation
   function automatic logic [65:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint p;
      int ia, ib;
      ia = a;
      ib = b;
      case (op)
         3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); return {2'b11, 64'(p)}; end
         3'd2: return {2'b11, {32'b0, a} * {32'b0, b}};
         3'd3: begin
            if (b == 0) return {2'b11, a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {2'b11, 32'h0, 32'h8000_0000};
            return {2'b11, 32'(ia % ib), 32'(ia / ib)};
         end
         3'd4: begin
            if (b == 0) return {2'b11, a, 32'hFFFF_FFFF};
            return {2'b11, a % b, a / b};
         end
         3'd5: return {2'b10, a, 32'h0};
         3'd6: return {2'b01, 32'h0, a};
         default: return '0;
      endcase
   endfunction
   function automatic int exp_stall(input logic [2:0] op);
      if (op == 3'd3 || op == 3'd4) return 33;
`ifdef MDU_MUL_2CYCLE_EN
      if (op == 3'd1 || op == 3'd2) return 1;
`endif
      return 0;
   endfunction
   function automatic logic [31:0] rnd();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction
   task automatic chk(input string name, input logic [99:0] got, input logic [99:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s got=%h expected=%h", name, got, want);
      end
   endtask
   // Monitor: every write is popped against the scoreboard; idle cycles must present zero data
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.we_o != 2'b00) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_write got we=%b hi=%h lo=%h expected no write", bus.we_o, bus.hi_o, bus.lo_o);
            end else begin
               logic [65:0] e;
               e = sb.pop_front();
               if ({bus.we_o, bus.hi_o, bus.lo_o} !== e) begin
                  n_bad++;
                  $display("FAIL result got we=%b hi=%h lo=%h expected we=%b hi=%h lo=%h",
                           bus.we_o, bus.hi_o, bus.lo_o, e[65:64], e[63:32], e[31:0]);
               end
            end
         end else begin
            n_cmp++;
            if (bus.hi_o != 0 || bus.lo_o != 0) begin
               n_bad++;
               $display("FAIL zero_data got hi=%h lo=%h expected 0", bus.hi_o, bus.lo_o);
            end
         end
      end
   end
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [65:0] e;
      int stalls;
      @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      e = model(op, a, b);
      if (e[65:64] != 2'b00) sb.push_back(e);
      stalls = 0;
      @(negedge clk);
      while (bus.stall_o && stalls < 40) begin
         stalls++;
         @(posedge clk);
         #1;
         @(negedge clk);
      end
      chk($sformatf("stall_len op=%0d", op), 100'(stalls), 100'(exp_stall(op)));
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.op    = 3'd0;
      @(negedge clk);
      chk("idle_after", {bus.stall_o, bus.we_o}, 3'b000);
   endtask
   initial begin
      bus.flushE = 1'b0;
      bus.start  = 1'b0;
      bus.op     = 3'd0;
      bus.a      = '0;
      bus.b      = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_state", {bus.stall_o, bus.we_o, bus.hi_o, bus.lo_o}, '0);
      run_op(3'd1, 32'hFFFF_FFFF, 32'd2);
      run_op(3'd2, 32'hFFFF_FFFF, 32'd2);
      run_op(3'd5, 32'h1234_5678, 32'd0);
      run_op(3'd6, 32'h8765_4321, 32'd0);
      run_op(3'd4, 32'd100, 32'd7);
      run_op(3'd3, 32'hFFFF_FFF9, 32'd2);
      run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op(3'd3, 32'd5, 32'd0);
      run_op(3'd3, 32'hFFFF_FFF0, 32'd0);
      // Flush at T+10 of a divide
      @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.op    = 3'd3;
      bus.a     = 32'd1000;
      bus.b     = 32'd3;
      repeat (10) @(posedge clk);
      #1;
      bus.flushE = 1'b1;
      @(negedge clk);
      chk("flush_cycle", {bus.stall_o, bus.we_o}, 3'b000);
      @(posedge clk);
      #1;
      bus.flushE = 1'b0;
      bus.start  = 1'b0;
      bus.op     = 3'd0;
      @(negedge clk);
      chk("flush_idle", {bus.stall_o, bus.we_o}, 3'b000);
      run_op(3'd4, 32'd9, 32'd3);
      // Reset in the middle of a divide
      @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.op    = 3'd3;
      bus.a     = 32'd123;
      bus.b     = 32'd4;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      bus.start = 1'b0;
      bus.op    = 3'd0;
      @(negedge clk);
      chk("reset_mid", {bus.stall_o, bus.we_o, bus.hi_o, bus.lo_o}, '0);
      for (int i = 0; i < 40; i++) run_op(3'($urandom_range(0, 7)), rnd(), rnd());
      @(posedge clk);
      chk("scoreboard_drain", 100'(sb.size()), 100'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Execute-stage multiply/divide unit for the MIPS core. It produces the write-enable and data pair that feed the HI/LO register file (hi_o/lo_o/we_o map onto hi_i/lo_i/we). It covers MULT/MULTU in a single cycle, DIV/DIVU as a 32-iteration radix-2 restoring divider, and MTHI/MTLO as pass-through. While a divide is in flight it stalls the pipeline.

Parameters:
DIV_ITERS, 32, number of divide iterations (one quotient bit per cycle); fixed at 32 for 32-bit operands.

Ports:
clk  input  1  core clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
flushE  input  1  execute-stage flush; aborts any operation
start  input  1  op valid in E stage; held high by the pipeline while stalled
op  input  3  000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; others are treated as NONE
a  input  32  rs operand (dividend / multiplicand / MTHI-MTLO source)
b  input  32  rt operand (divisor / multiplier)
stall_o  output  1  pipeline stall request
we_o  output  2  HI/LO write enable; [1]=HI, [0]=LO
hi_o  output  32  HI write data
lo_o  output  32  LO write data

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, counter=0, all datapath registers 0. Outputs in the following cycle: stall_o=0, we_o=00, hi_o=lo_o=0.
- hi_o and lo_o are 0 whenever we_o=00.
- States: IDLE, DIV_BUSY, DONE (plus MUL_WAIT when MDU_MUL_2CYCLE_EN is defined).
- IDLE, with start=1 and flushE=0:
  - MULT: combinational, same cycle. {hi_o,lo_o} = signed a*b (64-bit). we_o=11, stall_o=0. State stays IDLE.
  - MULTU: as MULT, with an unsigned product.
  - MTHI: hi_o=a, we_o=10. MTLO: lo_o=a, we_o=01. Same cycle, no stall.
  - DIV/DIVU: stall_o=1 combinationally in the start cycle T. At edge T the unit latches |a| and |b| (raw a and b for DIVU), both operand signs and the signedness. State goes to DIV_BUSY, counter=0.
- DIV_BUSY:
  - stall_o=1, we_o=00.
  - Each edge performs one restoring step: shift {rem,quo} left by 1; trial = rem - divisor; if the trial is non-negative, rem=trial and quo LSB=1.
  - The counter increments on each step; after the step with counter=31 the state goes to DONE.
  - DIV_BUSY lasts cycles T+1..T+32. stall_o is high for 33 cycles total (T..T+32).
- DONE (cycle T+33):
  - stall_o=0, we_o=11.
  - Signed op: lo_o = quotient, negated if the operand signs differ; hi_o = remainder, negated if the dividend is negative.
  - Unsigned op: raw quotient and remainder.
  - The state returns to IDLE unconditionally. start is still high from the held instruction and must not relaunch.
- Divide by zero (b=0, DIV or DIVU): handled by the normal 32-iteration path. Result is fixed at lo_o=32'hFFFF_FFFF and hi_o=a, with no sign correction applied.
- Signed overflow (0x80000000 / -1): lo_o=0x80000000, hi_o=0. No exception is raised.
- flushE=1 in any state, at any cycle: we_o=00 and stall_o=0 that cycle; next state=IDLE with the counter cleared. The result is discarded.
- rst has priority over flushE; flushE has priority over start.
- op or operand changes while in DIV_BUSY are ignored; the operands were latched at T.

Optional Feature:
MDU_MUL_2CYCLE_EN
- Defined: MULT/MULTU register the 64-bit product at edge T and go to MUL_WAIT.
  - stall_o=1 in cycle T.
  - In cycle T+1, state MUL_WAIT: we_o=11 with the registered product, stall_o=0, then back to IDLE.
  - flushE in either cycle aborts the operation with we_o=00.
- Undefined: MUL_WAIT does not exist, and multiplies complete combinationally in the start cycle.

Test Plan:
- MULT a=0xFFFFFFFF, b=2 -> same cycle we_o=11, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFE, stall_o=0.
- MULTU a=0xFFFFFFFF, b=2 -> hi_o=0x00000001, lo_o=0xFFFFFFFE. MTHI a=0x12345678 -> we_o=10, hi_o=0x12345678.
- DIVU a=100, b=7, start held -> stall_o=1 for exactly 33 cycles. Then one cycle with we_o=11, lo_o=0x0000000E, hi_o=0x00000002, then IDLE with no relaunch.
- DIV a=-7, b=2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
- DIV a=5, b=0 -> after 33 stall cycles: lo_o=0xFFFFFFFF, hi_o=0x00000005.
- DIV started, flushE=1 at cycle T+10 -> we_o=00 and stall_o=0 that cycle. Next cycle the state is IDLE. A following DIVU 9/3 completes normally with lo_o=3, hi_o=0. Also assert rst mid-divide -> all outputs 0 in the next cycle.
